icache: RTL
===========

Name: icache

Overview:
- Direct-mapped, one-word-block, read-only instruction cache between the pipelined datapath's fetch stage and the memory controller.
- Serves instruction fetches to the datapath. On a miss it issues a single-word read to memory, fills the frame, then hits.
- Sits directly upstream of the IF stage. Drives ihit/imemload; consumes imemREN/imemaddr.

Parameters:
- SETS, 16, number of frames; power of two, at least 2.
- IDX_W, $clog2(SETS), index width (derived, not overridable).
- TAG_W, 30-IDX_W, tag width (derived).

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  reset; asynchronous, active-low.
- imemREN  input  1  datapath fetch request.
- imemaddr  input  32  byte address of the fetch; bits [1:0] ignored.
- ihit  output  1  fetch data valid this cycle.
- imemload  output  32  instruction word.
- iREN  output  1  memory read request.
- iaddr  output  32  memory word address, bits [1:0] = 0.
- iwait  input  1  memory busy; low means iload is valid this cycle.
- iload  input  32  memory read data.
- hit_count  output  32  number of hits since reset, saturating.
- miss_count  output  32  number of misses since reset, saturating.

Behaviour:
- Address split: byte offset [1:0]; index [IDX_W+1:2]; tag [31:IDX_W+2].
- Frame storage: valid bit, TAG_W tag and 32-bit data per frame. Registers only, no SRAM macro.
- Reset (asynchronous, nRST=0):
  - all valid bits cleared; FSM goes to IDLE;
  - iREN=0, iaddr=0, ihit=0, imemload=0;
  - hit_count=0, miss_count=0;
  - tag and data arrays need not be cleared.
- FSM states: IDLE, FETCH.
- IDLE:
  - hit = imemREN && valid[idx] && tag[idx]==addr tag.
  - ihit=hit and imemload=data[idx], combinationally in the same cycle (0-cycle hit latency).
  - If imemREN and not hit: latch the word-aligned imemaddr into miss_addr, go to FETCH, increment miss_count.
  - While imemREN=0: ihit=0 and imemload=0. No state change and no counter change.
- FETCH:
  - iREN=1, iaddr=miss_addr, ihit=0.
  - When iwait=0: write valid=1, tag and data=iload into the frame at miss_addr's index, then return to IDLE.
  - The hit is seen in the following cycle. Miss latency = memory cycles + 1.
- Address change during FETCH: the fill completes for the latched miss_addr regardless. The new address is evaluated in IDLE afterwards.
- imemREN deasserted during FETCH: the fill still completes.
- Conflict: the fill overwrites the existing frame unconditionally. No write-back is needed; the cache is read-only.
- hit_count increments by 1 on each IDLE cycle with hit=1.
- Both counters saturate at 32'hFFFFFFFF and do not wrap.
- Reset asserted mid-FETCH: iREN drops immediately (asynchronously) and the partial fill is discarded.
- Simultaneous iwait=0 in the cycle of the FETCH entry decision is not possible, because iREN is only driven in FETCH.

Decomposition:
- Shared package (cache_types_pkg):
  - icache_frame_t struct (valid, tag, data);
  - icache_state_t enum {IDLE, FETCH};
  - address-field typedef icachef_t {tag, idx, bytoff}, sized from SETS.
- No sub-module. The frame array, FSM and counters fit in one module.
- The top level connects the datapath side through datapath_cache_if.

Test Plan:
- Reset, then imemREN=1, imemaddr=0x0000_0040 with memory returning 0x2002_0005 after iwait is high for 3 cycles. Required response:
  - iREN=1 with iaddr=0x40 for 4 cycles;
  - ihit=1 with imemload=0x2002_0005 on the next cycle;
  - miss_count=1, hit_count=1.
- Fetch 0x40 again 5 times → ihit=1 every cycle, iREN stays 0, hit_count=6.
- Fetch 0x80 (same index 0, different tag) and return 0xAAAA_0000, then refetch 0x40 → both are misses; the frame is overwritten each time and miss_count=3.
- Start a miss on 0x44, change imemaddr to 0x100 mid-FETCH → the fill goes to index 1 with the tag of 0x44. Next, 0x100 misses and iaddr=0x100.
- Assert nRST=0 during FETCH → iREN=0 in the same cycle. After reset, refetch 0x40 → miss (valid cleared), counters read 0 before the miss.
- imemaddr=0x43 (low bits set) after 0x40 is cached → hit with the same data; iaddr always has bits [1:0]=0 on misses.

Source files
------------

// File: rtl/cache_types_pkg.sv
// Shared types for the instruction cache: frame layout, FSM states, address split.
package cache_types_pkg;

    localparam int unsigned ICACHE_SETS  = 16;
    localparam int unsigned ICACHE_IDX_W = $clog2(ICACHE_SETS);
    localparam int unsigned ICACHE_TAG_W = 30 - ICACHE_IDX_W;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        logic [31:0]             data;
    } icache_frame_t;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icachef_t;

    // Saturating 32-bit increment for the event counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/datapath_cache_if.sv
// Fetch-stage side of the instruction cache.
interface datapath_cache_if;

    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;

    modport cache (
        input  imemREN,
        input  imemaddr,
        output ihit,
        output imemload
    );

    modport dp (
        output imemREN,
        output imemaddr,
        input  ihit,
        input  imemload
    );

endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-block, read-only instruction cache with hit/miss counters.
module icache
    import cache_types_pkg::*;
#(
    parameter int unsigned SETS = ICACHE_SETS
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 30 - IDX_W;

    datapath_cache_if dcif ();

    assign dcif.imemREN  = imemREN;
    assign dcif.imemaddr = imemaddr;
    assign ihit          = dcif.ihit;
    assign imemload      = dcif.imemload;

    icache_state_t    state_q, state_d;
    logic [31:0]      miss_addr_q, miss_addr_d;
    logic [31:0]      hit_cnt_q, hit_cnt_d;
    logic [31:0]      miss_cnt_q, miss_cnt_d;
    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q [SETS];
    logic [31:0]      data_q [SETS];

    logic [IDX_W-1:0] req_idx, fill_idx;
    logic [TAG_W-1:0] req_tag, fill_tag;
    logic             hit;
    logic             miss;
    logic             fill;

    // Byte offset never selects anything: blocks are one word wide.
    logic unused_byte_off;
    assign unused_byte_off = ^dcif.imemaddr[1:0];

    assign req_idx  = dcif.imemaddr[IDX_W+1:2];
    assign req_tag  = dcif.imemaddr[31:IDX_W+2];
    assign fill_idx = miss_addr_q[IDX_W+1:2];
    assign fill_tag = miss_addr_q[31:IDX_W+2];

    assign hit  = (state_q == IDLE) && dcif.imemREN && valid_q[req_idx]
                  && (tag_q[req_idx] == req_tag);
    assign miss = (state_q == IDLE) && dcif.imemREN && !hit;

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

    // Next-state, fill strobe and all datapath/memory-side outputs.
    always_comb begin
        state_d       = state_q;
        miss_addr_d   = miss_addr_q;
        fill          = 1'b0;
        iREN          = 1'b0;
        iaddr         = '0;
        dcif.ihit     = 1'b0;
        dcif.imemload = '0;
        unique case (state_q)
            IDLE: begin
                dcif.ihit = hit;
                if (hit) begin
                    dcif.imemload = data_q[req_idx];
                end
                if (miss) begin
                    miss_addr_d = {dcif.imemaddr[31:2], 2'b00};
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = miss_addr_q;
                // Fill targets the latched miss address even if the fetch address moved.
                if (!iwait) begin
                    fill    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Saturating hit/miss event counters.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (hit) begin
            hit_cnt_d = sat_inc(hit_cnt_q);
        end
        if (miss) begin
            miss_cnt_d = sat_inc(miss_cnt_q);
        end
    end

    // FSM state, miss address and counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // Valid bits are the only part of a frame that needs clearing on reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= '0;
        end else if (fill) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    // Tag and data storage, written only by a completed fill.
    always_ff @(posedge CLK) begin
        if (fill) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= iload;
        end
    end

endmodule
